// File: rtl/ioctl_router.sv
// Routes HPS ioctl download streams (ROM, variant select, DIP bank) to the core and sequences core_reset.
// Optional ROM checksum/length accumulator enabled by defining IOCTL_ROM_CKSUM_EN.
module ioctl_router #(
    parameter int RST_HOLD  = 255,
    parameter int MOD_COUNT = 18
) (
    input  logic                 clk_sys,
    input  logic                 RESET_N,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic [7:0]           ioctl_index,
    input  logic                 reset_req,
    output logic                 dn_wr,
    output logic [15:0]          dn_addr,
    output logic [7:0]           dn_data,
    output logic [7:0]           mod_sel,
    output logic [MOD_COUNT-1:0] mod_onehot,
    output logic [63:0]          sw_flat,
    output logic                 core_reset,
    output logic [15:0]          rom_sum,
    output logic [16:0]          rom_len
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_LOAD = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;
    localparam logic [15:0] RST_CNT = 16'(RST_HOLD);

    logic [1:0]           st_q, st_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 core_reset_q;
    logic                 dn_wr_q;
    logic [15:0]          dn_addr_q;
    logic [7:0]           dn_data_q;
    logic [7:0]           mod_sel_q;
    logic [MOD_COUNT-1:0] onehot_q, onehot_d;
    logic [63:0]          sw_q;
    logic                 rom_wr, mod_wr, sw_wr;

    assign rom_wr = ioctl_wr && (ioctl_index == 8'd0) && (ioctl_addr[24:16] == 9'd0);
    assign mod_wr = ioctl_wr && (ioctl_index == 8'd1);
    assign sw_wr  = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            dn_wr_q   <= 1'b0;
            dn_addr_q <= '0;
            dn_data_q <= '0;
            mod_sel_q <= '0;
            onehot_q  <= MOD_COUNT'(1);
            sw_q      <= '1;
        end else begin
            dn_wr_q  <= rom_wr;
            onehot_q <= onehot_d;
            if (rom_wr) begin
                dn_addr_q <= ioctl_addr[15:0];
                dn_data_q <= ioctl_dout;
            end
            if (mod_wr) mod_sel_q <= ioctl_dout;
            if (sw_wr) sw_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    // Out-of-range variants decode to no bit set.
    always_comb begin
        onehot_d = '0;
        for (int i = 0; i < MOD_COUNT; i++) onehot_d[i] = (mod_sel_q == 8'(i));
    end

    // Download takes priority in HOLD; reset_req keeps reloading the hold counter.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_IDLE: begin
                if (ioctl_download) begin
                    st_d = ST_LOAD;
                end else if (reset_req) begin
                    st_d  = ST_HOLD;
                    cnt_d = RST_CNT;
                end
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    st_d  = ST_HOLD;
                    cnt_d = RST_CNT;
                end
            end
            ST_HOLD: begin
                if (ioctl_download)     st_d  = ST_LOAD;
                else if (reset_req)     cnt_d = RST_CNT;
                else if (cnt_q == 16'd0) st_d = ST_IDLE;
                else                    cnt_d = cnt_q - 16'd1;
            end
            default: begin
                st_d  = ST_HOLD;
                cnt_d = RST_CNT;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q         <= ST_HOLD;
            cnt_q        <= RST_CNT;
            core_reset_q <= 1'b1;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            core_reset_q <= (st_d != ST_IDLE);
        end
    end

`ifdef IOCTL_ROM_CKSUM_EN
    logic [15:0] sum_q;
    logic [16:0] len_q;
    logic        cks_clr;

    assign cks_clr = (st_d == ST_LOAD) && (st_q != ST_LOAD) && (ioctl_index == 8'd0);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= '0;
            len_q <= '0;
        end else if (cks_clr) begin
            sum_q <= '0;
            len_q <= '0;
        end else if (dn_wr_q) begin
            sum_q <= sum_q + {8'd0, dn_data_q};
            if (len_q != 17'h1FFFF) len_q <= len_q + 17'd1;
        end
    end

    assign rom_sum = sum_q;
    assign rom_len = len_q;
`else
    assign rom_sum = '0;
    assign rom_len = '0;
`endif

    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign mod_sel    = mod_sel_q;
    assign mod_onehot = onehot_q;
    assign sw_flat    = sw_q;
    assign core_reset = core_reset_q;

endmodule

// File: tb/tb_ioctl_router.sv
// Randomized plus directed bench for ioctl_router against a behavioural reference model.
// Reset sequencing is modelled as "cycles since last download / reset_req activity".
module tb_ioctl_router;
    localparam int RST_HOLD  = 4;
    localparam int MOD_COUNT = 18;

    logic                 clk_sys = 1'b0;
    logic                 RESET_N = 1'b1;
    logic                 ioctl_download = 1'b0;
    logic                 ioctl_wr = 1'b0;
    logic [24:0]          ioctl_addr = '0;
    logic [7:0]           ioctl_dout = '0;
    logic [7:0]           ioctl_index = '0;
    logic                 reset_req = 1'b0;
    logic                 dn_wr;
    logic [15:0]          dn_addr;
    logic [7:0]           dn_data;
    logic [7:0]           mod_sel;
    logic [MOD_COUNT-1:0] mod_onehot;
    logic [63:0]          sw_flat;
    logic                 core_reset;
    logic [15:0]          rom_sum;
    logic [16:0]          rom_len;

    ioctl_router #(.RST_HOLD(RST_HOLD), .MOD_COUNT(MOD_COUNT)) dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .reset_req(reset_req), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .mod_sel(mod_sel),
        .mod_onehot(mod_onehot), .sw_flat(sw_flat), .core_reset(core_reset),
        .rom_sum(rom_sum), .rom_len(rom_len)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit        m_dn_wr;
    bit [15:0] m_dn_addr;
    bit [7:0]  m_dn_data;
    bit [7:0]  m_mod_sel;
    bit [MOD_COUNT-1:0] m_onehot;
    bit [7:0]  m_sw [8];
    int        since_dl, since_rr;
    bit        prev_dl;
    bit [15:0] m_sum;
    int        m_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_dn_wr   = 0;
        m_dn_addr = '0;
        m_dn_data = '0;
        m_mod_sel = '0;
        m_onehot  = MOD_COUNT'(1);
        for (int i = 0; i < 8; i++) m_sw[i] = 8'hFF;
        since_dl = 1000;
        since_rr = 0;
        prev_dl  = 0;
        m_sum    = '0;
        m_len    = 0;
    endfunction

    function automatic void model_edge();
        if (!RESET_N) begin
            model_reset();
            return;
        end
`ifdef IOCTL_ROM_CKSUM_EN
        if (ioctl_download && !prev_dl && ioctl_index == 8'd0) begin
            m_sum = '0;
            m_len = 0;
        end else if (m_dn_wr) begin
            m_sum = m_sum + 16'(m_dn_data);
            if (m_len < 131071) m_len++;
        end
`endif
        m_onehot = '0;
        if (m_mod_sel < MOD_COUNT) m_onehot[m_mod_sel] = 1'b1;
        m_dn_wr = ioctl_wr && ioctl_index == 8'd0 && ioctl_addr < 25'h10000;
        if (m_dn_wr) begin
            m_dn_addr = ioctl_addr[15:0];
            m_dn_data = ioctl_dout;
        end
        if (ioctl_wr && ioctl_index == 8'd1) m_mod_sel = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8) m_sw[ioctl_addr[2:0]] = ioctl_dout;
        since_dl = ioctl_download ? 0 : ((since_dl < 1000) ? since_dl + 1 : since_dl);
        since_rr = reset_req      ? 0 : ((since_rr < 1000) ? since_rr + 1 : since_rr);
        prev_dl  = ioctl_download;
    endfunction

    task automatic compare_all();
        logic [63:0] sw_exp;
        for (int i = 0; i < 8; i++) sw_exp[8*i +: 8] = m_sw[i];
        check("dn_wr",      64'(dn_wr),      64'(m_dn_wr));
        check("dn_addr",    64'(dn_addr),    64'(m_dn_addr));
        check("dn_data",    64'(dn_data),    64'(m_dn_data));
        check("mod_sel",    64'(mod_sel),    64'(m_mod_sel));
        check("mod_onehot", 64'(mod_onehot), 64'(m_onehot));
        check("sw_flat",    sw_flat,         sw_exp);
        check("core_reset", 64'(core_reset),
              64'((since_dl <= RST_HOLD + 1) || (since_rr <= RST_HOLD)));
        check("rom_sum",    64'(rom_sum),    64'(m_sum));
        check("rom_len",    64'(rom_len),    64'(m_len));
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_sys);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        step();
        ioctl_wr = 1'b0;
    endtask

    task automatic async_reset(input int cycles);
        RESET_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(cycles);
        RESET_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        async_reset(2);

        // reset release: core_reset stays high RST_HOLD+1 cycles
        step(7);
        check("rel_core_low", 64'(core_reset), 64'd0);
        check("rel_sw_flat", sw_flat, 64'hFFFF_FFFF_FFFF_FFFF);

        // ROM stream with out-of-range drop
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        step();
        wr_byte(8'd0, 25'h0000000, 8'hA5);
        check("rom_pulse0_addr", 64'(dn_addr), 64'h0000);
        wr_byte(8'd0, 25'h000FFFF, 8'h3C);
        check("rom_pulse1_data", 64'(dn_data), 64'h3C);
        wr_byte(8'd0, 25'h0010000, 8'h11);
        check("rom_drop_wr", 64'(dn_wr), 64'd0);
        step();
        ioctl_download = 1'b0;
        step(2);
`ifdef IOCTL_ROM_CKSUM_EN
        check("rom_sum_e1", 64'(rom_sum), 64'h00E1);
        check("rom_len_2", 64'(rom_len), 64'd2);
`endif
        step(6);

        // variant select
        wr_byte(8'd1, 25'h0000005, 8'h03);
        wr_byte(8'd1, 25'h1234567, 8'h11);
        step();
        check("mod_bit17", 64'(mod_onehot), 64'(18'h20000));
        wr_byte(8'd1, 25'h0, 8'h14);
        step();
        check("mod_oob_zero", 64'(mod_onehot), 64'd0);

        // DIP bank and ignored index
        wr_byte(8'd254, 25'd2, 8'h7E);
        wr_byte(8'd254, 25'd8, 8'h55);
        check("sw_byte2", sw_flat, 64'hFFFF_FFFF_FF7E_FFFF);
        wr_byte(8'd7, 25'd0, 8'h99);
        step();

        // download 10 high, 2 low, 3 high, then low
        ioctl_download = 1'b1; step(10);
        ioctl_download = 1'b0; step(2);
        ioctl_download = 1'b1; step(3);
        ioctl_download = 1'b0; step(5);
        check("dl_core_still_hi", 64'(core_reset), 64'd1);
        step();
        check("dl_core_fell", 64'(core_reset), 64'd0);

        // user reset request, including reload while holding
        reset_req = 1'b1; step();
        reset_req = 1'b0; step(2);
        reset_req = 1'b1; step();
        reset_req = 1'b0; step(7);

        // reset pulse in the middle of a ROM burst
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        step();
        wr_byte(8'd0, 25'h0000010, 8'h21);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0000011;
        ioctl_dout = 8'h22;
        step();
        ioctl_wr = 1'b0;
        async_reset(3);
        check("rst_abort_wr", 64'(dn_wr), 64'd0);
        step(4);
        wr_byte(8'd0, 25'h0000012, 8'h23);
        ioctl_download = 1'b0;
        step(8);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            ioctl_wr = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       ioctl_index = 8'd0;
                1:       ioctl_index = 8'd1;
                2:       ioctl_index = 8'd254;
                default: ioctl_index = 8'($urandom_range(2, 253));
            endcase
            case ($urandom_range(0, 2))
                0:       ioctl_addr = 25'($urandom_range(0, 15));
                1:       ioctl_addr = 25'($urandom_range(0, 65535));
                default: ioctl_addr = 25'($urandom);
            endcase
            ioctl_dout = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ioctl_download = ~ioctl_download;
            reset_req = ($urandom_range(0, 24) == 0);
            step();
        end
        ioctl_wr       = 1'b0;
        reset_req      = 1'b0;
        ioctl_download = 1'b0;
        step(8);
        check("end_core_low", 64'(core_reset), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
